// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch PC unit.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INS_W   = 20;
  localparam int OPC_W   = 5;
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 15;

  localparam logic [OPC_W-1:0] HALT_OPC = 5'b11110;
  localparam logic [INS_W-1:0] NOP_INS  = 20'h00000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    HALTED  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_pc_reg_unit.sv
// Program counter register: jump beats stall, stall beats increment; wraps modulo 2^PC_W.
module pc_reg_unit
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            stall,
  input  logic            pc_mux_sel,
  input  logic [PC_W-1:0] jmp_loc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;

  // Next-PC priority mux; a pending redirect is never lost to a stall.
  always_comb begin
    pc_next_s = pc_r;
    if (!en) begin
      pc_next_s = pc_r;
    end else if (pc_mux_sel) begin
      pc_next_s = jmp_loc;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + PC_W'(1);
    end
  end

  // PC state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= {PC_W{1'b0}};
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch end of the stall handshake: PC, held-instruction replay and run/stall/halt FSM.
// Optional stall-cycle counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             stall_pm,
  input  logic [INS_W-1:0] ins_pm,
  input  logic             pc_mux_sel,
  input  logic [PC_W-1:0]  jmp_loc,
  output logic [PC_W-1:0]  pc,
  output logic [INS_W-1:0] ins,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  fetch_state_e     state_r;
  fetch_state_e     state_next_s;
  logic [INS_W-1:0] held_ins_r;
  logic [INS_W-1:0] ins_r;
  logic [INS_W-1:0] ins_next_s;
  logic             halted_r;
  logic             halt_hit_s;
  logic             pc_en_s;

  assign pc_en_s = (state_r != HALTED);

  pc_reg_unit u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .en         (pc_en_s),
    .stall      (stall),
    .pc_mux_sel (pc_mux_sel),
    .jmp_loc    (jmp_loc),
    .pc         (pc)
  );

  // Halt is judged on the already-registered word, and not while it is being replayed.
  assign halt_hit_s = (ins_r[OPC_MSB:OPC_LSB] == HALT_OPC) && !stall_pm;

  // Next-state logic for the run/stall/halt FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (halt_hit_s) begin
          state_next_s = HALTED;
        end else if (stall && !pc_mux_sel) begin
          state_next_s = STALLED;
        end else begin
          state_next_s = RUN;
        end
      end
      STALLED: begin
        if (halt_hit_s) begin
          state_next_s = HALTED;
        end else if (!stall || pc_mux_sel) begin
          state_next_s = RUN;
        end else begin
          state_next_s = STALLED;
        end
      end
      HALTED: begin
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // Instruction presented to decode: bubble when halted, replay while stall_pm.
  always_comb begin
    ins_next_s = ins_pm;
    if (state_r == HALTED) begin
      ins_next_s = NOP_INS;
    end else if (stall_pm) begin
      ins_next_s = held_ins_r;
    end else begin
      ins_next_s = ins_pm;
    end
  end

  // FSM state, halted flag, held and presented instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      halted_r   <= 1'b0;
      held_ins_r <= NOP_INS;
      ins_r      <= NOP_INS;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == HALTED);
      ins_r    <= ins_next_s;
      if (!stall_pm) begin
        held_ins_r <= ins_pm;
      end else begin
        held_ins_r <= held_ins_r;
      end
    end
  end

  assign ins    = ins_r;
  assign halted = halted_r;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles spent in STALLED; naturally frozen once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == STALLED) && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed vectors push expectations, a monitor pops and compares.
module tb_fetch_pc_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        stall_pm;
  logic [19:0] ins_pm;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic [7:0]  pc;
  logic [19:0] ins;
  logic        halted;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [7:0]  pc;
    logic [19:0] ins;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .stall_pm   (stall_pm),
    .ins_pm     (ins_pm),
    .pc_mux_sel (pc_mux_sel),
    .jmp_loc    (jmp_loc),
    .pc         (pc),
    .ins        (ins),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare post-edge outputs against the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", {24'h0, pc}, {24'h0, e.pc});
      chk("ins", {12'h0, ins}, {12'h0, e.ins});
      chk("halted", {31'h0, halted}, {31'h0, e.halted});
      chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, (PERF ? e.cnt : 16'h0000)});
    end
  end

  task automatic vec(input logic r, input logic st, input logic spm, input logic [19:0] ipm,
                     input logic sel, input logic [7:0] jmp,
                     input logic [7:0] epc, input logic [19:0] eins, input logic eh,
                     input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    reset      = r;
    stall      = st;
    stall_pm   = spm;
    ins_pm     = ipm;
    pc_mux_sel = sel;
    jmp_loc    = jmp;
    e.pc = epc; e.ins = eins; e.halted = eh; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int waited;
    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; ins_pm = 20'h00000;
    pc_mux_sel = 1'b0; jmp_loc = 8'h00;

    // reset, then free run
    vec(1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h01, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h02, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b0, 16'd0);
    // stall three cycles at pc=3
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b0, 16'd1);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b0, 16'd2);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h04, 20'h00000, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h05, 20'h00000, 1'b0, 16'd3);
    // replay held instruction without PC freeze
    vec(1'b0, 1'b0, 1'b0, 20'ha0000, 1'b0, 8'h00, 8'h06, 20'ha0000, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 8'h00, 8'h07, 20'ha0000, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 8'h00, 8'h08, 20'ha0000, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b0, 20'h12345, 1'b0, 8'h00, 8'h09, 20'h12345, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h0a, 20'h00000, 1'b0, 16'd3);
    // jump wins over stall from RUN, then from STALLED
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b1, 8'h40, 8'h40, 20'h00000, 1'b0, 16'd3);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h41, 20'h00000, 1'b0, 16'd3);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h41, 20'h00000, 1'b0, 16'd3);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b1, 8'h80, 8'h80, 20'h00000, 1'b0, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h81, 20'h00000, 1'b0, 16'd4);
    // wrap through 8'hFF
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b1, 8'hfe, 8'hfe, 20'h00000, 1'b0, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'hff, 20'h00000, 1'b0, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h01, 20'h00000, 1'b0, 16'd4);
    // halt: one more increment, then frozen; jump and stall ignored
    vec(1'b0, 1'b0, 1'b0, 20'hf0000, 1'b0, 8'h00, 8'h02, 20'hf0000, 1'b0, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b1, 16'd4);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b1, 8'h55, 8'h03, 20'h00000, 1'b1, 16'd4);
    vec(1'b0, 1'b0, 1'b0, 20'ha0000, 1'b0, 8'h00, 8'h03, 20'h00000, 1'b1, 16'd4);
    // reset mid-halt
    vec(1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h01, 20'h00000, 1'b0, 16'd0);
    // halt word replayed under stall_pm does not halt until stall_pm drops
    vec(1'b0, 1'b0, 1'b0, 20'hf0000, 1'b0, 8'h00, 8'h02, 20'hf0000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b1, 20'h00000, 1'b0, 8'h00, 8'h03, 20'hf0000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h04, 20'h00000, 1'b1, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h04, 20'h00000, 1'b1, 16'd0);
    // reset mid-stall returns FSM to RUN
    vec(1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b1, 1'b1, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h00, 20'h00000, 1'b0, 16'd0);
    vec(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 8'h00, 8'h01, 20'h00000, 1'b0, 16'd0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
